mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous program/data memory between instruction fetch (P1) and load/store (P4).
//  Pipelined: one access issued per cycle, with configurable memory read latency.
//  Drives the stall that freezes P1/P2 when fetch loses the port.
//  Lets the pipelined core execute LD/ST without a second memory port.
// PARAMETERS
//  DW        16  data width (m_q, m_data, rdata)
//  AW        12  memory address width
//  RD_LAT    1   cycles from address edge to m_q sample edge; legal 1..4
//  ARB_MODE  0   0 = data always wins; 1 = round-robin on conflict (alternate winner)
// PORTS
//  clock     in   1   single clock, all state on posedge
//  reset     in   1   asynchronous, active-low; clears all state
//  if_req    in   1   fetch request, sampled each cycle
//  if_addr   in   AW  fetch address (PC)
//  if_flush  in   1   kill in-flight fetches (taken branch)
//  if_gnt    out  1   fetch accepted this cycle (combinational)
//  stall     out  1   if_req & ~if_gnt; freezes P1 PC and P2 IR
//  if_valid  out  1   one-cycle pulse, if_rdata valid
//  if_rdata  out  DW  fetched instruction
//  d_req     in   1   load/store request
//  d_we      in   1   1 = store, 0 = load
//  d_addr    in   AW  data address
//  d_wdata   in   DW  store data
//  d_gnt     out  1   data request accepted this cycle (combinational)
//  d_busy    out  1   accepted data op not yet done; d_req ignored while high
//  d_done    out  1   one-cycle pulse: load data valid / store written
//  d_rdata   out  DW  load result
//  m_addr    out  AW  memory address (registered)
//  m_data    out  DW  memory write data (registered)
//  m_rw      out  1   1 = write, 0 = read (registered)
//  m_q       in   DW  memory read data
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0; tag pipeline cleared; in-flight memory returns discarded.
//    No if_valid/d_done may pulse for accesses issued before reset.
//  - Grant, same cycle:
//    - d_gnt = d_req & ~d_busy & (ARB_MODE==0 | ~if_req | last_winner==FETCH).
//    - if_gnt = if_req & ~d_gnt.
//    - last_winner updates only on a conflict cycle.
//  - Issue: at the edge ending the grant cycle (T0), m_addr/m_rw/m_data load the granted request.
//    - With no grant: m_rw<=0; m_addr holds.
//    - m_rw=1 for exactly one cycle per store.
//  - Read return:
//    - Tag {valid, is_data} enters a RD_LAT-deep shift register at T0.
//    - m_q is sampled at edge T0+RD_LAT into if_rdata or d_rdata.
//    - if_valid/d_done pulse in the following cycle.
//    - Fetch latency: request cycle -> valid = RD_LAT+1 cycles.
//    - Back-to-back fetches give one if_valid per cycle, in issue order.
//  - Store: d_done pulses in the cycle after T0; d_rdata holds its previous value.
//  - d_busy: set at T0 of a data op; cleared in the cycle d_done pulses. At most one data op is outstanding.
//  - if_flush:
//    - Clears valid on all fetch tags in flight, including one returning this cycle.
//    - Does not affect data tags.
//    - A fetch granted in the same cycle as if_flush is kept.
//  - Reads never bypass a prior store. Same-address store then fetch returns the new data; the memory is write-first.
//  - Addresses wrap modulo 2^AW; no range check.
// STRUCTURE
//  - Shared package simple_ps_pkg:
//    - M_READ/M_WRITE encodings
//    - ARB_DATA_PRIO/ARB_ROUND_ROBIN constants
//    - tag_t {valid, is_data}
//    - RD_LAT_MAX=4
//  - Sub-module mem_tag_pipe: RD_LAT-deep tag shift register with per-class flush. Depth parameter, async active-low reset.
//  - Top level: grant logic, issue registers, return capture, d_busy flag.
// TESTING
//  1. Fetch stream, RD_LAT=1, if_req=1 with PC 0,1,2,3:
//     - if_valid high from cycle 2, one instruction per cycle, in order.
//     - stall=0 throughout.
//  2. Conflict, ARB_MODE=0, if_req+d_req(load 0x100):
//     - d_gnt=1, if_gnt=0, stall=1 for one cycle.
//     - d_rdata=mem[0x100] with d_done 2 cycles later.
//  3. Conflict, ARB_MODE=1, both requests held for 4 cycles:
//     - Grants alternate D,F,D,F.
//     - d_req is ignored while d_busy=1.
//  4. Store 0xBEEF to 0x010, then fetch 0x010:
//     - m_rw=1 for exactly one cycle.
//     - d_done pulses the next cycle.
//     - Fetch returns 0xBEEF.
//  5. RD_LAT=3, three fetches in flight, if_flush on the 2nd return cycle:
//     - Only the first if_valid appears.
//     - A fetch granted in the flush cycle returns normally.
//  6. reset=0 with a load in flight, released next cycle:
//     - All outputs 0, no d_done, d_busy=0.
//     - A new load completes with correct data.

Source files
------------

// File: rtl/simple_ps_pkg.sv
// simple_ps_pkg: shared encodings and types for the memory port arbiter.
//  M_READ/M_WRITE     memory direction encodings for m_rw
//  ARB_DATA_PRIO      arbitration mode: data always wins
//  ARB_ROUND_ROBIN    arbitration mode: alternate winner on conflict
//  WIN_FETCH/WIN_DATA last-winner state encodings
//  RD_LAT_MAX         largest supported memory read latency
//  tag_t              in-flight access tag {valid, is_data}
package simple_ps_pkg;
    localparam logic M_READ          = 1'b0;
    localparam logic M_WRITE         = 1'b1;
    localparam int   ARB_DATA_PRIO   = 0;
    localparam int   ARB_ROUND_ROBIN = 1;
    localparam logic WIN_FETCH       = 1'b0;
    localparam logic WIN_DATA        = 1'b1;
    localparam int   RD_LAT_MAX      = 4;
    typedef struct packed {
        logic valid;
        logic is_data;
    } tag_t;
endpackage

// File: rtl/mem_tag_pipe.sv
// mem_tag_pipe: DEPTH-deep shift register of access tags with fetch-class flush.
//  clock        in   posedge clock
//  reset        in   asynchronous active-low reset, clears all tags
//  tag_in       in   {valid, is_data} of the access issued this edge
//  flush_fetch  in   invalidate every fetch tag in flight, including the one at the output
//  tag_out      out  tag whose read data is on m_q this cycle
module mem_tag_pipe
    import simple_ps_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] tag_in,
    input  logic       flush_fetch,
    output logic [1:0] tag_out
);
    tag_t stage [DEPTH];

    function automatic tag_t kill(tag_t t, logic f);
        kill = t;
        if (f && !t.is_data) kill.valid = 1'b0;
    endfunction

    // The incoming tag is never flushed: a fetch granted alongside a flush is the new path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_t'(tag_in);
            for (int i = 1; i < DEPTH; i++) stage[i] <= kill(stage[i-1], flush_fetch);
        end
    end

    assign tag_out = kill(stage[DEPTH-1], flush_fetch);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction fetch and load/store.
//  clock, reset                         posedge clock, asynchronous active-low reset
//  if_req/if_addr/if_flush              fetch request, PC, kill in-flight fetches
//  if_gnt/stall/if_valid/if_rdata       fetch grant, pipeline freeze, return pulse and data
//  d_req/d_we/d_addr/d_wdata            load/store request
//  d_gnt/d_busy/d_done/d_rdata          data grant, op outstanding, completion pulse, load data
//  m_addr/m_data/m_rw                   registered memory command
//  m_q                                  memory read data, valid RD_LAT cycles after m_addr
module mem_port_arbiter
    import simple_ps_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 12,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = ARB_DATA_PRIO
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          stall,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_busy,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_data,
    output logic          m_rw,
    input  logic [DW-1:0] m_q
);
    logic last_winner;
    logic busy;
    tag_t tag_in;
    tag_t ret;

    assign d_gnt  = d_req && !busy && (ARB_MODE == ARB_DATA_PRIO || !if_req || last_winner == WIN_FETCH);
    assign if_gnt = if_req && !d_gnt;
    assign stall  = if_req && !if_gnt;
    assign d_busy = busy;

    // Stores complete without a memory return, so they carry an invalid tag.
    assign tag_in = d_gnt ? '{valid: !d_we, is_data: 1'b1} : '{valid: if_gnt, is_data: 1'b0};

    mem_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .clock       (clock),
        .reset       (reset),
        .tag_in      (tag_in),
        .flush_fetch (if_flush),
        .tag_out     (ret)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_winner <= WIN_FETCH;
            busy        <= 1'b0;
            m_addr      <= '0;
            m_data      <= '0;
            m_rw        <= M_READ;
            if_valid    <= 1'b0;
            if_rdata    <= '0;
            d_done      <= 1'b0;
            d_rdata     <= '0;
        end else begin
            m_addr   <= d_gnt ? d_addr : if_gnt ? if_addr : m_addr;
            m_data   <= d_gnt ? d_wdata : m_data;
            m_rw     <= (d_gnt && d_we) ? M_WRITE : M_READ;
            // Any cycle with both requests counts as a conflict, even while a load holds d_busy,
            // so a refused data request hands the next turn back to data.
            if (if_req && d_req) last_winner <= d_gnt ? WIN_DATA : WIN_FETCH;
            if_valid <= ret.valid && !ret.is_data;
            if (ret.valid && !ret.is_data) if_rdata <= m_q;
            d_done   <= (d_gnt && d_we) || (ret.valid && ret.is_data);
            if (ret.valid && ret.is_data) d_rdata <= m_q;
            busy     <= (d_gnt && !d_we) || (busy && !(ret.valid && ret.is_data));
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter in three configurations.
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int N  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req, if_flush, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt [N];
    logic          stall [N];
    logic          if_valid [N];
    logic          d_gnt [N];
    logic          d_busy [N];
    logic          d_done [N];
    logic          m_rw [N];
    logic [DW-1:0] if_rdata [N];
    logic [DW-1:0] d_rdata [N];
    logic [DW-1:0] m_data [N];
    logic [DW-1:0] m_q [N];
    logic [AW-1:0] m_addr [N];

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int cyc = 0;
    int first_fv = -1;
    int last_fv = -1;
    int n_fv = 0;
    int last_dd = -1;
    logic [DW-1:0] exp_f [$];
    logic [DW-1:0] exp_d [$];
    logic [DW-1:0] mon_e;
    logic [DW-1:0] last_ld;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return {a[3:0], a} ^ 16'h3C5A;
    endfunction

    // Instance 0: RD_LAT=1 data priority; 1: RD_LAT=1 round robin; 2: RD_LAT=3 data priority.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        bit ini = 1'b0;
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] qd [3];

        always @(posedge clock) begin
            if (!ini) begin
                for (int i = 0; i < 2**AW; i++) mem[i] <= init_val(i[AW-1:0]);
                ini <= 1'b1;
            end else if (m_rw[g]) begin
                mem[m_addr[g]] <= m_data[g];
            end
            qd[0] <= mem[m_addr[g]];
            qd[1] <= qd[0];
            qd[2] <= qd[1];
        end

        if (LAT == 1) begin : g_l1
            assign m_q[g] = mem[m_addr[g]];
        end else begin : g_ln
            assign m_q[g] = qd[LAT-2];
        end

        mem_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(LAT), .ARB_MODE(g == 1 ? 1 : 0)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_flush (if_flush),
            .if_gnt   (if_gnt[g]),
            .stall    (stall[g]),
            .if_valid (if_valid[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt[g]),
            .d_busy   (d_busy[g]),
            .d_done   (d_done[g]),
            .d_rdata  (d_rdata[g]),
            .m_addr   (m_addr[g]),
            .m_data   (m_data[g]),
            .m_rw     (m_rw[g]),
            .m_q      (m_q[g])
        );
    end

    always @(negedge clock) begin
        if (reset) begin
            if (if_valid[sel]) begin
                checks++;
                if (first_fv < 0) first_fv = cyc;
                last_fv = cyc;
                n_fv++;
                if (exp_f.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_return: unexpected if_valid with if_rdata=%h, none expected", if_rdata[sel]);
                end else begin
                    mon_e = exp_f.pop_front();
                    if (if_rdata[sel] !== mon_e) begin
                        errors++;
                        $display("FAIL fetch_return: if_rdata=%h expected %h", if_rdata[sel], mon_e);
                    end
                end
            end
            if (d_done[sel]) begin
                checks++;
                last_dd = cyc;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL data_return: unexpected d_done with d_rdata=%h, none expected", d_rdata[sel]);
                end else begin
                    mon_e = exp_d.pop_front();
                    if (d_rdata[sel] !== mon_e) begin
                        errors++;
                        $display("FAIL data_return: d_rdata=%h expected %h", d_rdata[sel], mon_e);
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        if_flush = 1'b0;
    endtask

    task automatic start_test(int s);
        sel = s;
        exp_f.delete();
        exp_d.delete();
        first_fv = -1;
        last_fv = -1;
        n_fv = 0;
        last_dd = -1;
    endtask

    task automatic settle(string nm);
        idle();
        repeat (8) nxt();
        checks++;
        if (exp_f.size() != 0 || exp_d.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d fetch / %0d data returns outstanding, expected 0 / 0", nm, exp_f.size(), exp_d.size());
        end
    endtask

    task automatic check_zero(string nm);
        checks++;
        if ({if_gnt[sel], stall[sel], if_valid[sel], d_gnt[sel], d_busy[sel], d_done[sel], m_rw[sel],
             if_rdata[sel], d_rdata[sel], m_data[sel], m_addr[sel]} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not zero (valid=%b done=%b busy=%b rw=%b addr=%h data=%h ifr=%h dr=%h)", nm,
                     if_valid[sel], d_done[sel], d_busy[sel], m_rw[sel], m_addr[sel], m_data[sel], if_rdata[sel], d_rdata[sel]);
        end
    endtask

    task automatic test_reset();
        start_test(0);
        idle();
        if_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset_state");
        nxt();
        reset = 1'b1;
        nxt();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] fa = 12'h020;
        logic [AW-1:0] da = 12'h100;
        logic exp_dg;
        start_test(1);
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1;
            if_addr = fa;
            d_req = 1'b1;
            d_we = 1'b0;
            d_addr = da;
            exp_dg = (k % 2 == 0);
            @(negedge clock);
            checks++;
            if ({d_gnt[1], if_gnt[1], d_busy[1]} !== {exp_dg, !exp_dg, !exp_dg}) begin
                errors++;
                $display("FAIL rr_grant_%0d: d_gnt/if_gnt/d_busy=%b%b%b expected %b%b%b", k,
                         d_gnt[1], if_gnt[1], d_busy[1], exp_dg, !exp_dg, !exp_dg);
            end
            if (exp_dg) begin
                exp_d.push_back(init_val(da));
                da++;
            end else begin
                exp_f.push_back(init_val(fa));
                fa++;
            end
            nxt();
        end
        settle("rr");
    endtask

    task automatic test_fetch_stream();
        int st;
        start_test(0);
        st = cyc;
        for (int pc = 0; pc < 4; pc++) begin
            if_req = 1'b1;
            if_addr = AW'(pc);
            @(negedge clock);
            checks++;
            if (if_gnt[0] !== 1'b1 || stall[0] !== 1'b0) begin
                errors++;
                $display("FAIL fetch_grant_%0d: if_gnt=%b stall=%b expected 1 0", pc, if_gnt[0], stall[0]);
            end
            exp_f.push_back(init_val(AW'(pc)));
            nxt();
        end
        settle("fetch");
        checks++;
        if (first_fv - st !== 2 || last_fv - first_fv !== 3 || n_fv !== 4) begin
            errors++;
            $display("FAIL fetch_timing: first at +%0d span %0d count %0d expected +2 span 3 count 4",
                     first_fv - st, last_fv - first_fv, n_fv);
        end
    endtask

    task automatic test_conflict_prio();
        int st;
        start_test(0);
        st = cyc;
        if_req = 1'b1;
        if_addr = 12'h005;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 12'h100;
        @(negedge clock);
        checks++;
        if ({d_gnt[0], if_gnt[0], stall[0]} !== 3'b101) begin
            errors++;
            $display("FAIL prio_grant: d_gnt/if_gnt/stall=%b%b%b expected 101", d_gnt[0], if_gnt[0], stall[0]);
        end
        exp_d.push_back(init_val(12'h100));
        last_ld = init_val(12'h100);
        nxt();
        d_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({if_gnt[0], stall[0], d_busy[0]} !== 3'b101) begin
            errors++;
            $display("FAIL prio_retry: if_gnt/stall/d_busy=%b%b%b expected 101", if_gnt[0], stall[0], d_busy[0]);
        end
        exp_f.push_back(init_val(12'h005));
        nxt();
        settle("prio");
        checks++;
        if (last_dd - st !== 2) begin
            errors++;
            $display("FAIL prio_load_latency: d_done at +%0d expected +2", last_dd - st);
        end
    endtask

    task automatic test_store_fetch();
        int st;
        start_test(0);
        st = cyc;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 12'h010;
        d_wdata = 16'hBEEF;
        @(negedge clock);
        checks++;
        if (d_gnt[0] !== 1'b1 || m_rw[0] !== 1'b0) begin
            errors++;
            $display("FAIL store_grant: d_gnt=%b m_rw=%b expected 1 0", d_gnt[0], m_rw[0]);
        end
        exp_d.push_back(last_ld);
        nxt();
        d_req = 1'b0;
        d_we = 1'b0;
        if_req = 1'b1;
        if_addr = 12'h010;
        @(negedge clock);
        checks++;
        if ({m_rw[0], m_addr[0], m_data[0], if_gnt[0], d_done[0]} !== {1'b1, 12'h010, 16'hBEEF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL store_issue: m_rw=%b m_addr=%h m_data=%h if_gnt=%b d_done=%b expected 1 010 beef 1 1",
                     m_rw[0], m_addr[0], m_data[0], if_gnt[0], d_done[0]);
        end
        exp_f.push_back(16'hBEEF);
        nxt();
        idle();
        @(negedge clock);
        checks++;
        if (m_rw[0] !== 1'b0) begin
            errors++;
            $display("FAIL store_one_cycle: m_rw=%b expected 0", m_rw[0]);
        end
        settle("store");
        checks++;
        if (last_dd - st !== 1) begin
            errors++;
            $display("FAIL store_done_time: d_done at +%0d expected +1", last_dd - st);
        end
    endtask

    task automatic test_flush();
        int st;
        start_test(2);
        st = cyc;
        for (int k = 0; k < 5; k++) begin
            if_req = (k != 3);
            if_addr = (k == 4) ? 12'h040 : AW'(12'h030 + k);
            if_flush = (k == 4);
            @(negedge clock);
            if (k != 3) begin
                checks++;
                if (if_gnt[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_grant_%0d: if_gnt=%b expected 1", k, if_gnt[2]);
                end
            end
            if (k == 0) exp_f.push_back(init_val(12'h030));
            if (k == 4) exp_f.push_back(init_val(12'h040));
            nxt();
        end
        settle("flush");
        checks++;
        if (first_fv - st !== 4 || last_fv - st !== 8 || n_fv !== 2) begin
            errors++;
            $display("FAIL flush_timing: valid at +%0d and +%0d count %0d expected +4 and +8 count 2",
                     first_fv - st, last_fv - st, n_fv);
        end
    endtask

    task automatic test_reset_inflight();
        start_test(0);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 12'h055;
        @(negedge clock);
        checks++;
        if (d_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_load_grant: d_gnt=%b expected 1", d_gnt[0]);
        end
        nxt();
        idle();
        reset = 1'b0;
        @(negedge clock);
        check_zero("reset_inflight");
        nxt();
        reset = 1'b1;
        repeat (3) nxt();
        checks++;
        if (d_busy[0] !== 1'b0 || last_dd !== -1) begin
            errors++;
            $display("FAIL rst_discard: d_busy=%b d_done_seen=%0d expected 0 and none", d_busy[0], last_dd);
        end
        d_req = 1'b1;
        d_addr = 12'h077;
        @(negedge clock);
        exp_d.push_back(init_val(12'h077));
        nxt();
        settle("rst_new_load");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fetch_stream();
        test_conflict_prio();
        test_store_fetch();
        test_flush();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
